pipe_buffer_elastic: RTL and testbench

Parametrised elastic pipeline register chain for inter-stage buffering in the pipelined CPU datapath. It extends the plain flush/hold buffer in four ways: a configurable number of stages, a valid/ready handshake on both sides, bubble collapsing, and a per-stage selective flush. Flushed or empty stages present all-zero data, so a bubble always decodes as a NOP. Instances sit between fetch/decode/execute/memory stages and absorb multi-cycle stalls without pausing upstream logic unnecessarily.

---
 rtl/pipe_buffer_elastic.sv | 149 ++++++++++++++
 tb/tb_pipe_buffer_elastic.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_buffer_elastic.sv
// pipe_buffer_elastic
//
// Elastic register chain placed between CPU pipeline stages. Payloads move
// from stage 0 (youngest) towards stage STAGES-1 (oldest, drives the output)
// under a valid/ready handshake. Empty stages never block: a payload keeps
// sliding forward into any empty slot ahead of it. Each stage can be flushed
// individually, and a global hold freezes the whole chain.
//
// Parameters:
//   N              payload width in bits (1..128)
//   STAGES         number of register stages (1..8)
//   CLEAR_ON_FLUSH 1: flushed/bubble stages carry all-zero data (decodes as NOP)
//                  0: only the valid bit is cleared, data is left as-is
//
// Ports:
//   clock       rising-edge clock
//   reset       asynchronous active-low reset, clears all state while low
//   in_valid    upstream offers in_data
//   in_data     upstream payload
//   in_ready    chain accepts in_data this cycle
//   out_valid   oldest stage holds a payload (masked by hold)
//   out_data    payload of the oldest stage (not masked)
//   out_ready   downstream consumes out_data this cycle
//   hold        freeze every stage; flush still applies
//   flush_mask  bit i invalidates stage i at this edge
//   occupancy   number of valid stages (registered)

module pipe_buffer_elastic #(
  parameter int N              = 16,
  parameter int STAGES         = 2,
  parameter int CLEAR_ON_FLUSH = 1
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             in_valid,
  input  logic [N-1:0]                     in_data,
  output logic                             in_ready,
  output logic                             out_valid,
  output logic [N-1:0]                     out_data,
  input  logic                             out_ready,
  input  logic                             hold,
  input  logic [STAGES-1:0]                flush_mask,
  output logic [$clog2(STAGES+1)-1:0]      occupancy
);

  localparam int OCC_W = $clog2(STAGES + 1);

  // Stage state
  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] valid_d;
  logic [N-1:0]      data_q [STAGES];
  logic [N-1:0]      data_d [STAGES];
  logic [OCC_W-1:0]  occ_q;
  logic [OCC_W-1:0]  occ_d;

  // adv[i]: the content of stage i moves on at this edge (to i+1, or out).
  // load[i]: stage i takes whatever its source presents at this edge.
  logic [STAGES-1:0] adv;
  logic [STAGES-1:0] load;

  // Advance chain, resolved from the oldest stage back to the youngest so a
  // ready at the output ripples through every full stage in one cycle.
  always_comb begin
    adv = '0;
    adv[STAGES-1] = out_ready & ~hold;
    for (int i = STAGES - 2; i >= 0; i--) begin
      adv[i] = ~hold & (~valid_q[i+1] | adv[i+1]);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      logic         src_valid;
      logic [N-1:0] src_data;
      logic         v_d;
      logic [N-1:0] d_d;

      // A stage takes new content when it is empty or its content moves on.
      assign load[gi] = ~hold & (~valid_q[gi] | adv[gi]);

      if (gi == 0) begin : g_head
        assign src_valid = in_valid;
        assign src_data  = in_data;
      end else begin : g_body
        assign src_valid = valid_q[gi-1];
        assign src_data  = data_q[gi-1];
      end

      always_comb begin
        v_d = valid_q[gi];
        d_d = data_q[gi];
        if (load[gi]) begin
          v_d = src_valid;
          if (src_valid) begin
            d_d = src_data;
          end else if (CLEAR_ON_FLUSH != 0) begin
            // Bubbles carry zero data so they always decode as a NOP.
            d_d = '0;
          end
        end
        // Flush wins over any load into this stage, and over hold. A payload
        // leaving this stage is unaffected: its destination's bit decides.
        if (flush_mask[gi]) begin
          v_d = 1'b0;
          if (CLEAR_ON_FLUSH != 0) begin
            d_d = '0;
          end
        end
      end

      assign valid_d[gi] = v_d;
      assign data_d[gi]  = d_d;
    end
  endgenerate

  // Occupancy is computed from the next valid vector so it is registered in
  // step with valid_q.
  always_comb begin
    occ_d = '0;
    for (int i = 0; i < STAGES; i++) begin
      occ_d = occ_d + OCC_W'(valid_d[i]);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      occ_q   <= '0;
      for (int i = 0; i < STAGES; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      occ_q   <= occ_d;
      for (int i = 0; i < STAGES; i++) begin
        data_q[i] <= data_d[i];
      end
    end
  end

  // in_ready is forced low while reset is held so nothing is offered as
  // accepted during reset; it rises as soon as reset releases.
  assign in_ready  = reset & load[0];
  assign out_valid = valid_q[STAGES-1] & ~hold;
  assign out_data  = data_q[STAGES-1];
  assign occupancy = occ_q;

endmodule

// File: tb/tb_pipe_buffer_elastic.sv
module tb_pipe_buffer_elastic;

  localparam int N      = 16;
  localparam int STAGES = 3;

  logic              clock;
  logic              reset;
  logic              in_valid;
  logic [N-1:0]      in_data;
  logic              in_ready;
  logic              out_valid;
  logic [N-1:0]      out_data;
  logic              out_ready;
  logic              hold;
  logic [STAGES-1:0] flush_mask;
  logic [1:0]        occupancy;

  int total = 0;
  int bad   = 0;

  pipe_buffer_elastic #(
    .N(N),
    .STAGES(STAGES),
    .CLEAR_ON_FLUSH(1)
  ) dut (
    .clock(clock),
    .reset(reset),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_ready(out_ready),
    .hold(hold),
    .flush_mask(flush_mask),
    .occupancy(occupancy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge and settle just after it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    int occ_exp;
    int lo;
    int hi;

    reset      = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    out_ready  = 1'b0;
    hold       = 1'b0;
    flush_mask = '0;

    // ---------------- reset state ----------------
    #3;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  32'(out_data),  32'd0);
    check("rst_occupancy", 32'(occupancy), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd0);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // ---------------- streaming 1..8 ----------------
    // Item k is accepted at edge k and sits in stage j-k after edge j.
    out_ready = 1'b1;
    for (int j = 1; j <= 11; j++) begin
      in_valid = (j <= 8);
      in_data  = (j <= 8) ? 16'(j) : 16'h0000;
      step();
      lo = (j - 2 > 1) ? j - 2 : 1;
      hi = (j < 8) ? j : 8;
      occ_exp = (hi >= lo) ? hi - lo + 1 : 0;
      check($sformatf("stream_occ_%0d", j), 32'(occupancy), 32'(occ_exp));
      if (j >= 3 && j - 2 <= 8) begin
        check($sformatf("stream_ov_%0d", j), 32'(out_valid), 32'd1);
        check($sformatf("stream_od_%0d", j), 32'(out_data), 32'(j - 2));
      end else begin
        check($sformatf("stream_ov_%0d", j), 32'(out_valid), 32'd0);
        check($sformatf("stream_od_%0d", j), 32'(out_data), 32'd0);
      end
    end
    in_valid = 1'b0;

    // ---------------- backpressure ----------------
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data = 16'h00A1; step();
    in_data = 16'h00A2; step();
    in_data = 16'h00A3; step();
    in_valid = 1'b0;
    check("bp_full_occ",     32'(occupancy), 32'd3);
    check("bp_full_inready", 32'(in_ready),  32'd0);
    step();
    step();
    check("bp_stall_occ",  32'(occupancy), 32'd3);
    check("bp_stall_data", 32'(out_data),  32'h00A1);
    check("bp_stall_ov",   32'(out_valid), 32'd1);
    out_ready = 1'b1;
    #1;
    check("bp_passthru_inready", 32'(in_ready), 32'd1);
    check("bp_out0", 32'(out_data), 32'h00A1);
    step();
    check("bp_out1", 32'(out_data), 32'h00A2);
    check("bp_occ1", 32'(occupancy), 32'd2);
    step();
    check("bp_out2", 32'(out_data), 32'h00A3);
    check("bp_occ2", 32'(occupancy), 32'd1);
    step();
    check("bp_drained_ov",  32'(out_valid), 32'd0);
    check("bp_drained_occ", 32'(occupancy), 32'd0);

    // ---------------- bubble collapse ----------------
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'h0011; step();
    in_valid = 1'b0; step();
    step();
    in_valid = 1'b1; in_data = 16'h0022; step();
    in_valid = 1'b0; step();
    step();
    check("bub_occ",    32'(occupancy),    32'd2);
    check("bub_out",    32'(out_data),     32'h0011);
    check("bub_valid",  32'(dut.valid_q),  32'b110);
    check("bub_stage1", 32'(dut.data_q[1]), 32'h0022);
    out_ready = 1'b1;
    step();
    check("bub_drain_out", 32'(out_data), 32'h0022);
    step();
    check("bub_drain_occ", 32'(occupancy), 32'd0);

    // ---------------- selective flush ----------------
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 16'h00B0; step();
    in_data = 16'h00B1; step();
    in_data = 16'h00B2; step();
    in_valid = 1'b0;
    check("fl_full_occ", 32'(occupancy), 32'd3);
    flush_mask = 3'b011;
    step();
    flush_mask = 3'b000;
    check("fl_occ",    32'(occupancy),     32'd1);
    check("fl_out",    32'(out_data),      32'h00B0);
    check("fl_ov",     32'(out_valid),     32'd1);
    check("fl_valid",  32'(dut.valid_q),   32'b100);
    check("fl_data0",  32'(dut.data_q[0]), 32'd0);
    check("fl_data1",  32'(dut.data_q[1]), 32'd0);
    out_ready = 1'b1;
    step();
    check("fl_drain_occ", 32'(occupancy), 32'd0);

    // ---------------- hold vs flush ----------------
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 16'h00C0; step();
    in_data = 16'h00C1; step();
    in_data = 16'h00C2; step();
    out_ready = 1'b1;
    hold = 1'b1;
    in_data = 16'h00DD;
    #1;
    check("hold_ov",      32'(out_valid), 32'd0);
    check("hold_inready", 32'(in_ready),  32'd0);
    for (int c = 0; c < 4; c++) begin
      step();
      check($sformatf("hold_occ_%0d", c),  32'(occupancy), 32'd3);
      check($sformatf("hold_data_%0d", c), 32'(out_data),  32'h00C0);
    end
    flush_mask = 3'b100;
    step();
    flush_mask = 3'b000;
    check("hf_occ",    32'(occupancy),     32'd2);
    check("hf_out",    32'(out_data),      32'd0);
    check("hf_valid",  32'(dut.valid_q),   32'b011);
    check("hf_data1",  32'(dut.data_q[1]), 32'h00C1);
    check("hf_data0",  32'(dut.data_q[0]), 32'h00C2);
    in_valid = 1'b0;
    hold = 1'b0;
    #1;
    check("hf_release_ov", 32'(out_valid), 32'd0);
    step();
    check("hf_out_c1", 32'(out_data), 32'h00C1);
    step();
    check("hf_out_c2", 32'(out_data), 32'h00C2);
    step();
    check("hf_drain_occ", 32'(occupancy), 32'd0);

    // ---------------- async reset mid-stream ----------------
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 16'h00E1; step();
    in_data = 16'h00E2; step();
    in_valid = 1'b0;
    step();
    check("ar_pre_occ", 32'(occupancy), 32'd2);
    check("ar_pre_out", 32'(out_data),  32'h00E1);
    #2;
    reset = 1'b0;
    #1;
    check("ar_out_data", 32'(out_data),  32'd0);
    check("ar_out_valid", 32'(out_valid), 32'd0);
    check("ar_occ",      32'(occupancy), 32'd0);
    check("ar_inready",  32'(in_ready),  32'd0);
    step();
    #2;
    reset = 1'b1;
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_data = 16'h5A5A;
    #1;
    check("ar_release_inready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    in_data = 16'h0000;
    check("ar_lat_e0", 32'(out_valid), 32'd0);
    step();
    check("ar_lat_e1", 32'(out_valid), 32'd0);
    step();
    check("ar_lat_e2_ov", 32'(out_valid), 32'd1);
    check("ar_lat_e2_od", 32'(out_data),  32'h5A5A);
    step();
    check("ar_final_occ", 32'(occupancy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
